// File: rtl/acc_arb_pkg.sv
// Shared types and defaults for the packet-level accumulator stream arbiter.
package acc_arb_pkg;
  localparam int N_SRC_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first requester at or after ptr, wrapping modulo N_SRC.
module rr_pick
  import acc_arb_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = id_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_SRC-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      j = int'(ptr) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/acc_stream_arb.sv
// Packet-locked round-robin arbiter sharing one accumulator stream sink between N_SRC producers.
module acc_stream_arb
  import acc_arb_pkg::*;
#(
  parameter int N_SRC  = N_SRC_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = id_w(N_SRC),
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        s_tvalid,
  input  logic [N_SRC*DATA_W-1:0] s_tdata,
  input  logic [N_SRC-1:0]        s_tlast,
  output logic [N_SRC-1:0]        s_tready,
  output logic                    m_tvalid,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [ID_W-1:0]         m_tid,
  output logic [N_SRC-1:0]        grant,
  output logic                    busy,
  output logic                    pkt_done,
  output logic [CNT_W-1:0]        pkt_cnt
);
  arb_state_t       state;
  logic [ID_W-1:0]  gidx;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  next_ptr;
  logic [N_SRC-1:0] pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             locked;
  logic             accept;

  rr_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
    .req (s_tvalid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign locked   = (state == LOCKED);
  assign busy     = locked;
  assign m_tid    = gidx;
  assign accept   = m_tvalid & m_tready;
  assign next_ptr = (gidx == ID_W'(N_SRC - 1)) ? '0 : gidx + 1'b1;

  // Pass-through is gated by state, so reset (state=IDLE) forces every path to zero.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (locked) begin
      m_tvalid = s_tvalid[gidx];
      m_tdata  = s_tdata[int'(gidx)*DATA_W +: DATA_W];
      m_tlast  = s_tlast[gidx];
      s_tready = grant & {N_SRC{m_tready}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      gidx     <= '0;
      rr_ptr   <= '0;
      pkt_done <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state <= LOCKED;
            grant <= pick_gnt;
            gidx  <= pick_idx;
          end
        end
        LOCKED: begin
          // Grant is held through source bubbles; only an accepted tlast releases it.
          if (accept && m_tlast) begin
            state    <= IDLE;
            grant    <= '0;
            gidx     <= '0;
            rr_ptr   <= next_ptr;
            pkt_done <= 1'b1;
            pkt_cnt  <= pkt_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_stream_arb.sv
// Scoreboard bench for acc_stream_arb: per-source packet queues drive the inputs, expected beats are checked in order.
module tb_acc_stream_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int CW = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      s_tvalid;
  logic [N*DW-1:0]   s_tdata;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic              m_tvalid;
  logic [DW-1:0]     m_tdata;
  logic              m_tlast;
  logic              m_tready;
  logic [IW-1:0]     m_tid;
  logic [N-1:0]      grant;
  logic              busy;
  logic              pkt_done;
  logic [CW-1:0]     pkt_cnt;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  beat_t        exp_q[$];
  logic [DW:0]  src_q[N][$];
  int           checks = 0;
  int           errors = 0;
  int           acc_cnt = 0;
  int           done_cnt = 0;
  int           sum = 0;
  logic         tog = 1'b0;
  logic         stalled = 1'b0;
  logic [DW-1:0] stall_data;
  logic [N-1:0] fire;

  acc_stream_arb #(.N_SRC(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .m_tid    (m_tid),
    .grant    (grant),
    .busy     (busy),
    .pkt_done (pkt_done),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic void drive_srcs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = src_q[i][0][DW:1];
        s_tlast[i]           = src_q[i][0][0];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tlast[i]           = 1'b0;
      end
    end
  endfunction

  // Packet of n consecutive values starting at first; expected beats follow push order.
  task automatic push_pkt(input int src, input int first, input int n);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      src_q[src].push_back({DW'(first + k), (k == n - 1)});
      e.data = DW'(first + k);
      e.id   = IW'(src);
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
    drive_srcs();
  endtask

  // Monitor + source driver: sample at negedge, advance queues just after posedge.
  initial begin
    beat_t e;
    logic [N-1:0] one;
    one = 1;
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      if (m_tvalid && m_tready) begin
        acc_cnt++;
        sum += int'(m_tdata);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%0d tid=%0d, none expected", m_tdata, m_tid);
        end else begin
          e = exp_q.pop_front();
          if ({m_tdata, m_tid, m_tlast} !== {e.data, e.id, e.last}) begin
            errors++;
            $display("FAIL beat: got data=%0d tid=%0d last=%0b, want data=%0d tid=%0d last=%0b",
                     m_tdata, m_tid, m_tlast, e.data, e.id, e.last);
          end
          checks++;
          if (grant !== (one << e.id)) begin
            errors++;
            $display("FAIL grant_onehot: got %b want %b", grant, one << e.id);
          end
        end
      end
      if (stalled && m_tvalid) begin
        checks++;
        if (m_tdata !== stall_data) begin
          errors++;
          $display("FAIL stall_hold: got %0d want %0d", m_tdata, stall_data);
        end
      end
      stalled    = m_tvalid && !m_tready;
      stall_data = m_tdata;
      if (pkt_done) done_cnt++;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (tog) m_tready = ~m_tready;
      drive_srcs();
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    tog      = 1'b0;
    m_tready = 1'b1;
    drive_srcs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    acc_cnt  = 0;
    done_cnt = 0;
    sum      = 0;
    stalled  = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while ((exp_q.size() > 0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (exp_q.size() > 0 || busy) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats outstanding, busy=%0b", name, exp_q.size(), busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_tready = 1'b1;
    drive_srcs();
    #3;
    checks++;
    if ({grant, busy, m_tvalid, m_tlast, s_tready, m_tid, m_tdata, pkt_done, pkt_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: grant=%b busy=%0b m_tvalid=%0b s_tready=%b pkt_cnt=%0d pkt_done=%0b",
               grant, busy, m_tvalid, s_tready, pkt_cnt, pkt_done);
    end
  endtask

  task automatic test_single_src();
    do_reset();
    push_pkt(0, 1, 3);
    wait_drain(30, "single_src");
    checks++;
    if (sum !== 6) begin errors++; $display("FAIL single_sum: got %0d want 6", sum); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", done_cnt); end
    checks++;
    if (pkt_cnt !== CW'(1)) begin errors++; $display("FAIL single_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) push_pkt(i, 10 * i, 2);
    push_pkt(0, 100, 2);
    wait_drain(60, "round_robin");
    checks++;
    if (pkt_cnt !== CW'(5)) begin errors++; $display("FAIL rr_cnt: got %0d want 5", pkt_cnt); end
    checks++;
    if (done_cnt !== 5) begin errors++; $display("FAIL rr_done: got %0d want 5", done_cnt); end
  endtask

  task automatic test_lock();
    int c = 0;
    do_reset();
    push_pkt(1, 11, 3);
    while (acc_cnt < 1 && c < 20) begin @(negedge clk); c++; end
    push_pkt(0, 1, 2);
    c = 0;
    while (!pkt_done && c < 20) begin
      checks++;
      if (s_tready[0] !== 1'b0) begin
        errors++;
        $display("FAIL lock_ready0: got s_tready[0]=%0b want 0 while src1 locked", s_tready[0]);
      end
      @(negedge clk);
      c++;
    end
    checks++;
    if (!pkt_done) begin
      errors++;
      $display("FAIL lock_timeout: pkt_done never seen");
    end else begin
      checks++;
      if (busy !== 1'b0 || grant !== '0) begin
        errors++;
        $display("FAIL lock_idle_gap: got busy=%0b grant=%b want 0/0000", busy, grant);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || m_tid !== 2'd0 || grant !== 4'b0001) begin
        errors++;
        $display("FAIL lock_regrant: got busy=%0b tid=%0d grant=%b want 1/0/0001", busy, m_tid, grant);
      end
    end
    wait_drain(30, "lock");
    checks++;
    if (pkt_cnt !== CW'(2)) begin errors++; $display("FAIL lock_cnt: got %0d want 2", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_tready = 1'b0;
    tog      = 1'b1;
    push_pkt(2, 5, 4);
    wait_drain(40, "backpressure");
    tog      = 1'b0;
    m_tready = 1'b1;
    checks++;
    if (sum !== 26) begin errors++; $display("FAIL bp_sum: got %0d want 26", sum); end
    checks++;
    if (acc_cnt !== 4) begin errors++; $display("FAIL bp_beats: got %0d want 4", acc_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    int c = 0;
    do_reset();
    push_pkt(3, 31, 4);
    while (acc_cnt < 2 && c < 20) begin @(negedge clk); c++; end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== '0) begin
      errors++;
      $display("FAIL midrst_async: got grant=%b busy=%0b m_tvalid=%0b s_tready=%b want all 0",
               grant, busy, m_tvalid, s_tready);
    end
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    drive_srcs();
    done_cnt = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (pkt_cnt !== '0 || done_cnt !== 0 || pkt_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nodone: got pkt_cnt=%0d pulses=%0d want 0/0", pkt_cnt, done_cnt);
    end
    rst = 1'b1;
    push_pkt(0, 9, 1);
    push_pkt(3, 7, 1);
    wait_drain(30, "midrst");
    checks++;
    if (pkt_cnt !== CW'(2)) begin errors++; $display("FAIL midrst_cnt: got %0d want 2", pkt_cnt); end
  endtask

  task automatic test_cnt_wrap();
    int c = 0;
    do_reset();
    for (int i = 0; i < (1 << CW) - 1; i++) push_pkt(0, i, 1);
    wait_drain(4 * (1 << CW), "wrap_preload");
    checks++;
    if (pkt_cnt !== {CW{1'b1}}) begin
      errors++;
      $display("FAIL wrap_preload_cnt: got %0d want %0d", pkt_cnt, (1 << CW) - 1);
    end
    push_pkt(0, 77, 1);
    while (!pkt_done && c < 20) begin @(negedge clk); c++; end
    checks++;
    if (pkt_done !== 1'b1 || pkt_cnt !== '0) begin
      errors++;
      $display("FAIL wrap: got pkt_done=%0b pkt_cnt=%0d want 1/0", pkt_done, pkt_cnt);
    end
    wait_drain(10, "wrap");
  endtask

  initial begin
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    test_reset();
    test_single_src();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_stream_arb.md
Name: acc_stream_arb

Overview:
Packet-level round-robin arbiter that shares one accumulator stream sink between N_SRC AXI-stream producers. Grants one source at a time and locks the grant until that source's tlast beat is accepted, so packets are never interleaved at the accumulator. Sits directly upstream of the accumulator receiver. Reports the granted source ID and packet-completion events for status logic.

Parameters:
N_SRC, 4, number of requesting sources (2..16)
DATA_W, 32, payload width of every stream
ID_W, $clog2(N_SRC), width of source ID
CNT_W, 16, width of completed-packet counter

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-low
s_tvalid  in  N_SRC  per-source valid
s_tdata  in  N_SRC*DATA_W  per-source payload; source i occupies bits [i*DATA_W +: DATA_W]
s_tlast  in  N_SRC  per-source end-of-packet
s_tready  out  N_SRC  per-source ready
m_tvalid  out  1  valid to accumulator
m_tdata  out  DATA_W  payload to accumulator
m_tlast  out  1  end-of-packet to accumulator
m_tready  in  1  ready from accumulator (may depend combinationally on m_tvalid)
m_tid  out  ID_W  index of granted source; 0 when not locked
grant  out  N_SRC  one-hot registered grant; all-zero when idle
busy  out  1  1 while in LOCKED
pkt_done  out  1  one-cycle pulse after a tlast beat is accepted
pkt_cnt  out  CNT_W  packets completed since reset, wraps

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, grant=0, pkt_cnt=0, pkt_done=0. Combinational outputs m_tvalid, m_tlast, s_tready, m_tid and m_tdata are forced to 0.
- FSM with 2 states.
- IDLE:
  - m_tvalid=0; all s_tready=0.
  - If any s_tvalid: pick the first requester at or after rr_ptr, wrapping modulo N_SRC. Register its grant and go to LOCKED.
  - 1-cycle arbitration latency: no beat passes in IDLE.
- LOCKED, granted index g:
  - Combinational pass-through: m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], m_tlast=s_tlast[g], s_tready[g]=m_tready.
  - s_tready of every other source = 0.
- Beat accepted = m_tvalid & m_tready.
- Accepted beat with m_tlast=1:
  - next cycle: state=IDLE, grant=0, rr_ptr=(g+1) mod N_SRC;
  - pkt_done=1 for exactly that cycle;
  - pkt_cnt+=1, wrapping from 2^CNT_W-1 to 0.
- Minimum gap between packets is one idle cycle.
- Grant is held while s_tvalid[g] drops mid-packet (bubble). No timeout and no re-arbitration until tlast.
- Non-granted sources may assert or deassert s_tvalid freely. They see no ready and must hold data (AXI rule).
- A source must not make s_tvalid depend on s_tready. The m_tready→s_tready path is combinational and introduces no loop.
- Single-beat packet (tlast on first beat): LOCKED for one accepted beat, then IDLE.
- Reset mid-packet:
  - the packet is abandoned and no pkt_done is generated;
  - the source must restart the packet after reset.
- m_tid equals the binary index of grant while LOCKED.

Decomposition:
- Package acc_arb_pkg holds:
  - default N_SRC/DATA_W/CNT_W localparams;
  - arb_state_t enum {IDLE, LOCKED};
  - ID_W function/constant.
- Sub-module rr_pick: purely combinational rotating-priority encoder.
  - Inputs: req[N_SRC], ptr[ID_W].
  - Outputs: gnt one-hot, idx, any.
- FSM, counters and muxing live in acc_stream_arb.

Test Plan:
1. Only src0 sends 3-beat packet 1,2,3 with m_tready=1 → m_tdata 1,2,3 with m_tid=0; m_tlast on beat 3; pkt_done pulse; pkt_cnt=1; downstream sum=6.
2. All 4 sources request from reset, each sending 2-beat packet {10i, 10i+1} → packets appear in order src0,1,2,3, then src0 again. Never interleaved; pkt_cnt=4 after first round.
3. src1 is mid-packet when src0 asserts valid → s_tready[0]=0 until src1's tlast accepted. Then rr_ptr=2; with only src0 requesting, src0 is granted after one idle cycle.
4. m_tready toggles every cycle (phase-style sink), src2 sends 4 beats 5,6,7,8 → each beat transferred exactly once; m_tdata stable while m_tready=0; sum 26.
5. rst pulsed low after beat 2 of a 4-beat src3 packet → grant=0, busy=0, m_tvalid=0 asynchronously. No pkt_done, pkt_cnt=0, next arbitration starts at src0.
6. Preload by running 65535 single-beat packets, then one more → pkt_cnt wraps to 0 with pkt_done asserted.
